// File: rtl/gpio_stream_port_if.sv
// Data-memory bus target port plus 8-bit GPIO stream.
// Master = pipeline/sink side, slave = gpio_stream_port.
interface gpio_stream_port_if;
  logic        wmem;
  logic        rmem;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        sel;
  logic [7:0]  gpio_data;
  logic        gpio_valid;
  logic        gpio_ready;

  modport master (
    output wmem, rmem, addr, wdata, gpio_ready,
    input  rdata, sel, gpio_data, gpio_valid
  );

  modport slave (
    input  wmem, rmem, addr, wdata, gpio_ready,
    output rdata, sel, gpio_data, gpio_valid
  );
endinterface

// File: rtl/gpio_stream_port.sv
// Store-fed byte FIFO draining to a valid/ready GPIO stream.
// Optional output pacing via macro GPIO_PACE_EN.
module gpio_stream_port #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
  parameter int          DEPTH       = 8,
  parameter int          PACE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  gpio_stream_port_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   rd_q, wr_q;
  logic [CW-1:0]   count_q;
  logic [7:0]      last_q;
  logic [7:0]      data_q;
  logic            en_q, ovf_q;
  logic            sel_data, sel_stat, sel_ctrl;
  logic            full, empty;
  logic            push_req, push_ok, ovf_set, ovf_clr;
  logic            load, xfer, can_load;
  logic            b2b, pace_ok, pace_busy;
  logic [31:0]     status;
  logic            unused;

  assign sel_data = bus.addr == BASE_ADDR;
  assign sel_stat = bus.addr == BASE_ADDR + 32'd1;
  assign sel_ctrl = bus.addr == BASE_ADDR + 32'd2;
  assign bus.sel  = sel_data | sel_stat | sel_ctrl;

  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == '0;

  assign push_req = bus.wmem && sel_data;
  assign push_ok  = push_req && (!full || load);
  assign ovf_set  = push_req && full && !load;
  assign ovf_clr  = bus.wmem && sel_ctrl && bus.wdata[1];

  assign xfer     = (state_q == SEND) && bus.gpio_ready;
  assign can_load = en_q && !empty && pace_ok;

`ifdef GPIO_PACE_EN
  localparam int PW = $clog2(PACE_CYCLES + 2);
  logic [PW-1:0] pace_q;

  // Counter expiring at this edge already allows the next load.
  assign b2b       = 1'b0;
  assign pace_ok   = pace_q <= PW'(1);
  assign pace_busy = pace_q != '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pace_q <= '0;
    end else if (xfer) begin
      pace_q <= PW'(PACE_CYCLES);
    end else if (pace_q != '0) begin
      pace_q <= pace_q - PW'(1);
    end
  end
`else
  logic unused_pace;
  assign unused_pace = |PACE_CYCLES;
  assign b2b         = 1'b1;
  assign pace_ok     = 1'b1;
  assign pace_busy   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (can_load) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.gpio_ready) begin
          if (can_load && b2b) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) data_q <= mem[rd_q];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= bus.wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      last_q  <= '0;
      en_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_q   <= wr_q + AW'(1);
        last_q <= bus.wdata[7:0];
      end
      if (load) rd_q <= rd_q + AW'(1);
      if (push_ok && !load) begin
        count_q <= count_q + CW'(1);
      end else if (!push_ok && load) begin
        count_q <= count_q - CW'(1);
      end
      if (bus.wmem && sel_ctrl) en_q <= bus.wdata[0];
      // Set wins over a simultaneous clear.
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign status = {21'b0, pace_busy, ovf_q,
                   5'(count_q), 2'b0, empty, full};

  always_comb begin
    bus.rdata = '0;
    unique case (1'b1)
      sel_data: bus.rdata = {24'b0, last_q};
      sel_stat: bus.rdata = status;
      sel_ctrl: bus.rdata = {31'b0, en_q};
      default:  bus.rdata = '0;
    endcase
  end

  assign bus.gpio_valid = state_q == SEND;
  assign bus.gpio_data  = data_q;

  assign unused = ^{bus.rmem, bus.wdata[31:8]};
endmodule

// File: tb/tb_gpio_stream_port.sv
// Scoreboard bench for gpio_stream_port: directed stores,
// queue of expected stream bytes checked by a monitor.
module tb_gpio_stream_port;
  localparam logic [31:0] BASE = 32'h0000_0400;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] exp_q [$];

  gpio_stream_port_if bus();

  gpio_stream_port dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a,
                       input logic [31:0] d);
    bus.wmem  = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    tick();
    bus.wmem  = 1'b0;
    bus.addr  = 32'h0;
  endtask

  task automatic rd(input string name,
                    input logic [31:0] a,
                    input logic [31:0] exp);
    bus.addr = a;
    #1;
    chk(name, bus.rdata, exp);
    bus.addr = 32'h0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      tick();
      k++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: a transfer completes at the next rising edge.
  always @(negedge clk) begin
    if (rst && bus.gpio_valid && bus.gpio_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_byte: got %h expected none",
                 bus.gpio_data);
      end else begin
        chk("stream_byte", {24'b0, bus.gpio_data},
            {24'b0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    logic v [40];
    int nv, run, maxrun, gap, last;
    logic gap_ok;

    bus.wmem = 0; bus.rmem = 0;
    bus.addr = 0; bus.wdata = 0;
    bus.gpio_ready = 0;
    tick(); tick();
    rst = 1'b1;

    // reset state and address decode
    bus.addr = BASE + 1;
    #1;
    chk("sel_status", {31'b0, bus.sel}, 32'd1);
    chk("valid_reset", {31'b0, bus.gpio_valid}, 32'd0);
    chk("data_reset", {24'b0, bus.gpio_data}, 32'd0);
    rd("status_reset", BASE + 1, 32'h2);
    rd("ctrl_reset", BASE + 2, 32'h1);
    rd("data_reg_reset", BASE, 32'h0);
    bus.addr = BASE + 3;
    #1;
    chk("sel_outside", {31'b0, bus.sel}, 32'd0);
    rd("rdata_outside", BASE + 3, 32'h0);

    // single byte, ready high
    bus.gpio_ready = 1'b1;
    exp_q.push_back(8'h78);
    store(BASE, 32'h1234_5678);
    chk("valid_after_push", {31'b0, bus.gpio_valid}, 32'd0);
    tick();
    chk("valid_one_cycle", {31'b0, bus.gpio_valid}, 32'd1);
    chk("data_one_cycle", {24'b0, bus.gpio_data}, 32'h78);
    tick();
    chk("valid_drop", {31'b0, bus.gpio_valid}, 32'd0);
    rd("data_reg_last", BASE, 32'h78);

    // overflow with en off, then clear and drain
    store(BASE + 2, 32'h0);
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_q.push_back(8'(i));
      store(BASE, 32'hFFFF_FF00 | 32'(i));
    end
    rd("status_overflow", BASE + 1, 32'h281);
    chk("no_stream_en0", {31'b0, bus.gpio_valid}, 32'd0);
    store(BASE + 2, 32'h3);
    rd("status_ovf_clr", BASE + 1, 32'h81);
    drain("drain_overflow");
    repeat (8) tick();
    rd("status_after_drain", BASE + 1, 32'h2);

    // stall: data held while ready low
    bus.gpio_ready = 1'b0;
    exp_q.push_back(8'hA5);
    store(BASE, 32'hA5);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'b0, bus.gpio_valid}, 32'd1);
      chk("stall_data", {24'b0, bus.gpio_data}, 32'hA5);
      tick();
    end
    bus.gpio_ready = 1'b1;
    tick();
    chk("stall_released", {31'b0, bus.gpio_valid}, 32'd0);
    chk("stall_consumed", 32'(exp_q.size()), 32'd0);

    // full FIFO, push on the same edge as a pop
    store(BASE + 2, 32'h0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'h31 + 8'(i));
      store(BASE, 32'h31 + 32'(i));
    end
    rd("status_full", BASE + 1, 32'h81);
    store(BASE + 2, 32'h1);
    exp_q.push_back(8'h39);
    store(BASE, 32'h39);
    rd("status_push_pop", BASE + 1, 32'h81);
    drain("drain_full");
    repeat (8) tick();
    rd("status_empty_again", BASE + 1, 32'h2);

    // reset mid-transfer discards the byte
    bus.gpio_ready = 1'b0;
    store(BASE, 32'hEE);
    tick();
    chk("pre_reset_valid", {31'b0, bus.gpio_valid}, 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("reset_drops_valid", {31'b0, bus.gpio_valid}, 32'd0);
    chk("reset_clears_data", {24'b0, bus.gpio_data}, 32'd0);
    rd("status_post_reset", BASE + 1, 32'h2);
    bus.gpio_ready = 1'b1;

    // streaming rate: three bytes
    store(BASE + 2, 32'h0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h51 + 8'(i));
      store(BASE, 32'h51 + 32'(i));
    end
    store(BASE + 2, 32'h1);
    for (int i = 0; i < 40; i++) begin
      tick();
      v[i] = bus.gpio_valid;
    end
    nv = 0; run = 0; maxrun = 0;
    last = -1; gap_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (v[i]) begin
        nv++;
        run++;
        if (run > maxrun) maxrun = run;
        gap = i - last - 1;
        if (last >= 0 && gap != 0 && gap != 4) gap_ok = 1'b0;
        last = i;
      end else begin
        run = 0;
      end
    end
    chk("rate_valid_cycles", 32'(nv), 32'd3);
`ifdef GPIO_PACE_EN
    chk("pace_max_run", 32'(maxrun), 32'd1);
    chk("pace_gap_4", {31'b0, gap_ok}, 32'd1);
`else
    chk("b2b_max_run", 32'(maxrun), 32'd3);
`endif
    chk("rate_consumed", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
